load_queue: RTL

Parametrised successor to the single-cell load latch. It buffers up to DEPTH Braille cell codes of WIDTH bits from the input decoder, then presents them in order to the display/compare logic over a valid/take handshake. It adds occupancy reporting, backpressure, a sticky overflow flag and a synchronous flush. An optional overwrite mode turns the buffer into a "keep the newest DEPTH cells" ring.

---
 rtl/load_queue.sv | 86 ++++++++
 1 files changed

// File: rtl/load_queue.sv
// Ordered buffer of Braille cell codes between the input decoder and the display/compare logic.
// Registered head/valid/count outputs; optional "keep newest DEPTH" overwrite ring.
module load_queue #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 4,
    parameter int OVERWRITE = 0
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [WIDTH-1:0]           In,
    input  logic                       Valid,
    output logic                       Ready,
    input  logic                       Take,
    input  logic                       Clear,
    output logic [WIDTH-1:0]           Out,
    output logic                       OutValid,
    output logic [$clog2(DEPTH+1)-1:0] Count,
    output logic                       Overflow,
    output logic                       enable
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr, rd_nxt, wr_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic [WIDTH-1:0] head_nxt;
    logic             full, push, pop, drop, ovf_set;

    assign full  = (Count == CW'(DEPTH));
    assign Ready = !full || (OVERWRITE != 0);
    assign push  = Valid && Ready;
    assign pop   = Take && OutValid;
    // Overwrite push into a full queue with no pop: the oldest entry is discarded.
    assign drop  = push && full && !pop;
    // A push+pop on a full overwrite queue is an ordinary exchange, not an overflow.
    assign ovf_set = Valid && full && !((OVERWRITE != 0) && pop);

    always_comb begin
        rd_nxt  = (pop || drop) ? rd_ptr + PW'(1) : rd_ptr;
        wr_nxt  = push ? wr_ptr + PW'(1) : wr_ptr;
        cnt_nxt = Count;
        if (push && !pop && !full)
            cnt_nxt = Count + CW'(1);
        else if (pop && !push)
            cnt_nxt = Count - CW'(1);
        // New head is the cell being written this edge when it lands at the read slot.
        head_nxt = (push && rd_nxt == wr_ptr) ? In : mem[rd_nxt];
    end

    always_ff @(posedge Clk) begin
        if (push && !Clear)
            mem[wr_ptr] <= In;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            Count    <= '0;
            Out      <= '0;
            OutValid <= 1'b0;
            Overflow <= 1'b0;
            enable   <= 1'b0;
        end else if (Clear) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            Count    <= '0;
            Out      <= '0;
            OutValid <= 1'b0;
            Overflow <= 1'b0;
            enable   <= 1'b0;
        end else begin
            rd_ptr   <= rd_nxt;
            wr_ptr   <= wr_nxt;
            Count    <= cnt_nxt;
            OutValid <= (cnt_nxt != '0);
            if (cnt_nxt != '0)
                Out <= head_nxt;
            if (ovf_set)
                Overflow <= 1'b1;
            if (push)
                enable <= 1'b1;
        end
    end
endmodule
